cam_tx: RTL and testbench

CAM_TX -- requirements
Module: cam_tx

---
 rtl/cam_tx_pkg.sv | 26 ++
 rtl/cam_tx_baud.sv | 30 +++
 rtl/cam_tx.sv | 131 +++++++++++++
 tb/tb_cam_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cam_tx_pkg.sv
// cam_tx shared types and geometry.
// CAM_TX_PARITY_EN adds the PARITY state.
package cam_tx_pkg;

  localparam int IMG_W         = 26;
  localparam int IMG_H         = 26;
  localparam int PIX_W         = 8;
  localparam int CLK_DIV_DEF   = 425;
  localparam int FRAME_PIX_DEF = IMG_W * IMG_H;

`ifdef CAM_TX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    PARITY
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA
  } state_t;
`endif

endpackage

// File: rtl/cam_tx_baud.sv
// cam_tx bit-period counter.
// tick marks a bit's first cycle, last its final cycle.
module cam_tx_baud #(
  parameter int CLK_DIV = 425
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic last
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == '0);
  assign last = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cam_tx.sv
// cam_tx: serial pixel transmitter, start bit then MSB-first data.
// Build option CAM_TX_PARITY_EN appends an even-parity bit.
module cam_tx
  import cam_tx_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int FRAME_PIX = FRAME_PIX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             cam_data,
  output logic             bit_tick,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);

  localparam int PW = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

  state_t           state;
  state_t           state_nx;
  logic [PIX_W-1:0] sh;
  logic [2:0]       bcnt;
  logic [PW-1:0]    pcnt;
  logic             tick;
  logic             last;
  logic             restart;
  logic             hs;
  logic             byte_end;
  logic             wrap;
  logic             last_data;
`ifdef CAM_TX_PARITY_EN
  logic             par;
`endif

  assign restart   = (state == IDLE);
  assign busy      = (state != IDLE);
  assign bit_tick  = tick && busy;
  assign last_data = last && (state == DATA)
                  && (bcnt == 3'(PIX_W - 1));
`ifdef CAM_TX_PARITY_EN
  assign byte_end  = last && (state == PARITY);
`else
  assign byte_end  = last_data;
`endif
  assign pix_ready = !rst && en
                  && ((state == IDLE) || byte_end);
  assign hs        = pix_valid && pix_ready;
  assign wrap      = (pcnt == PW'(FRAME_PIX - 1));

  cam_tx_baud #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick),
    .last    (last)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (hs) state_nx = START;
      START:  if (last) state_nx = DATA;
`ifdef CAM_TX_PARITY_EN
      DATA:   if (last_data) state_nx = PARITY;
      PARITY: if (last) state_nx = hs ? START : IDLE;
`else
      DATA:   if (last_data) state_nx = hs ? START : IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cam_data = 1'b0;
    unique case (state)
      START:  cam_data = 1'b1;
      DATA:   cam_data = sh[PIX_W-1];
`ifdef CAM_TX_PARITY_EN
      PARITY: cam_data = par;
`endif
      default: cam_data = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sh         <= '0;
      bcnt       <= '0;
      pcnt       <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      if (hs) begin
        sh <= pix_data;
      end else if (state == DATA && last) begin
        sh <= {sh[PIX_W-2:0], 1'b0};
      end
      if (state == DATA && last) begin
        bcnt <= bcnt + 3'd1;
      end
      // en low at byte end is a clean stop, not a missing byte
      if (byte_end) begin
        pcnt       <= wrap ? '0 : pcnt + PW'(1);
        frame_done <= wrap;
        underrun   <= !wrap && !hs && en;
      end
    end
  end

`ifdef CAM_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (hs) begin
      par <= ^pix_data;
    end
  end
`endif

endmodule

// File: tb/tb_cam_tx.sv
// Directed bench for cam_tx at CLK_DIV=4.
// Parity cases run when CAM_TX_PARITY_EN is defined.
module tb_cam_tx;

`ifdef CAM_TX_PARITY_EN
  localparam int NB = 10;
  localparam logic [39:0] EXP_A5 = 40'hFF0F00F0F0;
  localparam logic [39:0] EXP_3C = 40'hF00FFFF000;
  localparam logic [39:0] EXP_TK = 40'h8888888888;
  localparam logic [39:0] EXP_BZ = 40'hFFFFFFFFFF;
`else
  localparam int NB = 9;
  localparam logic [39:0] EXP_A5 = 40'h0FF0F00F0F;
  localparam logic [39:0] EXP_3C = 40'h0F00FFFF00;
  localparam logic [39:0] EXP_TK = 40'h0888888888;
  localparam logic [39:0] EXP_BZ = 40'h0FFFFFFFFF;
`endif
  localparam int CYC = NB * 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       cam_data;
  logic       bit_tick;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  int n_err;
  int n_chk;

  cam_tx #(
    .CLK_DIV   (4),
    .FRAME_PIX (676)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .cam_data   (cam_data),
    .bit_tick   (bit_tick),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {cam_data, pix_ready, bit_tick, busy, frame_done, underrun};
  endfunction

  task automatic send_one(input logic [7:0] d, input int drop_at,
                          output logic [39:0] cd, output logic [39:0] tk,
                          output logic [39:0] bz, output logic [39:0] rd,
                          output logic [5:0] post);
    cd = '0; tk = '0; bz = '0; rd = '0;
    @(negedge clk);
    pix_data  = d;
    pix_valid = 1'b1;
    for (int i = 0; i < CYC; i++) begin
      @(negedge clk);
      if (i == 0) pix_valid = 1'b0;
      if (i == drop_at) en = 1'b0;
      cd = {cd[38:0], cam_data};
      tk = {tk[38:0], bit_tick};
      bz = {bz[38:0], busy};
      rd = {rd[38:0], pix_ready};
    end
    @(negedge clk);
    post = outs();
  endtask

  task automatic run_bytes(input int n, output int sent,
                           output int busy_c, output int fd_c,
                           output int fd_at, output int un_c,
                           output int un_at);
    sent = 0; busy_c = 0; fd_c = 0; fd_at = 0; un_c = 0; un_at = 0;
    @(negedge clk);
    pix_data  = 8'h40;
    pix_valid = 1'b1;
    if (pix_ready) sent++;
    for (int c = 1; c <= n * CYC + 2; c++) begin
      @(negedge clk);
      if (sent == n) pix_valid = 1'b0;
      if (pix_valid && pix_ready) begin
        sent++;
        pix_data = 8'(sent) ^ 8'h5A;
      end
      busy_c += int'(busy);
      if (frame_done) begin
        fd_c++;
        if (fd_at == 0) fd_at = c;
      end
      if (underrun) begin
        un_c++;
        if (un_at == 0) un_at = c;
      end
    end
  endtask

  logic [39:0] cd, tk, bz, rd;
  logic [5:0]  post;
  int          sent, busy_c, fd_c, fd_at, un_c, un_at;
  logic        leak;

  initial begin
    n_err     = 0;
    n_chk     = 0;
    rst       = 1'b1;
    en        = 1'b1;
    pix_valid = 1'b1;
    pix_data  = 8'hFF;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 6'b000000);
    rst       = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", outs(), 6'b010000);

    send_one(8'hA5, -1, cd, tk, bz, rd, post);
    chk("a5_cam_data", cd, EXP_A5);
    chk("a5_bit_tick", tk, EXP_TK);
    chk("a5_busy", bz, EXP_BZ);
    chk("a5_ready_last", rd, 40'h1);
    chk("a5_post_underrun", post, 6'b010001);

    en = 1'b1;
    send_one(8'h3C, 13, cd, tk, bz, rd, post);
    chk("en_drop_cam_data", cd, EXP_3C);
    chk("en_drop_busy", bz, EXP_BZ);
    chk("en_drop_ready", rd, 40'h0);
    chk("en_drop_post", post, 6'b000000);

    leak      = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'hFF;
    repeat (4) begin
      @(negedge clk);
      leak = leak | busy | pix_ready;
    end
    pix_valid = 1'b0;
    chk("ignore_valid", leak, 1'b0);

    en = 1'b1;
    @(negedge clk);
    pix_data  = 8'hFF;
    pix_valid = 1'b1;
    leak      = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 0) pix_valid = 1'b0;
      leak = leak | frame_done | underrun;
    end
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_outs", outs(), 6'b000000);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", outs(), 6'b010000);
    leak = leak | frame_done | underrun;
    chk("reset_no_pulse", leak, 1'b0);

    run_bytes(676, sent, busy_c, fd_c, fd_at, un_c, un_at);
    chk("frame_sent", sent, 676);
    chk("frame_no_gap", busy_c, 676 * CYC);
    chk("frame_done_cnt", fd_c, 1);
    chk("frame_done_at", fd_at, 676 * CYC + 1);
    chk("frame_underrun", un_c, 0);

    run_bytes(10, sent, busy_c, fd_c, fd_at, un_c, un_at);
    chk("ur_busy", busy_c, 10 * CYC);
    chk("ur_count", un_c, 1);
    chk("ur_at", un_at, 10 * CYC + 1);
    chk("ur_no_frame", fd_c, 0);
    chk("ur_line_low", {cam_data, busy}, 2'b00);

    run_bytes(666, sent, busy_c, fd_c, fd_at, un_c, un_at);
    chk("resume_done_cnt", fd_c, 1);
    chk("resume_done_at", fd_at, 666 * CYC + 1);
    chk("resume_underrun", un_c, 0);

`ifdef CAM_TX_PARITY_EN
    send_one(8'h07, -1, cd, tk, bz, rd, post);
    chk("par07_cam_data", cd, 40'hF00000FFFF);
    send_one(8'h03, -1, cd, tk, bz, rd, post);
    chk("par03_cam_data", cd, 40'hF000000FF0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
